// File: rtl/requant_pkg.sv
// rtl/requant_pkg.sv - shared widths, saturation limits and FSM states for the requant stage
package requant_pkg;
  localparam int LANES    = 8;
  localparam int ACC_W    = 32;
  localparam int OUT_W    = 8;
  localparam int PACK     = 4;
  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  typedef enum logic [2:0] {
    IDLE,
    Q0,
    S0,
    Q1,
    S1
  } state_e;
endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - one-lane round-half-up shift, optional ReLU and int8 saturation
module requant_lane
  import requant_pkg::*;
(
  input  logic signed [ACC_W-1:0] psum,
  input  logic        [4:0]       shift,
  input  logic                    relu,
  output logic signed [OUT_W-1:0] q
);

  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(INT8_MAX);
  localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(INT8_MIN);

  logic signed [ACC_W:0] x;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] y;

  // One guard bit keeps the rounding add from wrapping at the int32 extremes.
  always_comb begin
    x   = {psum[ACC_W-1], psum};
    rnd = '0;
    if (shift != 5'd0) begin
      rnd = {{ACC_W{1'b0}}, 1'b1} << (shift - 5'd1);
    end
    y = (x + rnd) >>> shift;
    if (relu && (y < 0)) begin
      y = '0;
    end
    if (y > SAT_HI) begin
      q = OUT_W'(INT8_MAX);
    end else if (y < SAT_LO) begin
      q = OUT_W'(INT8_MIN);
    end else begin
      q = y[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/ofmap_requant.sv
// rtl/ofmap_requant.sv - captures a psum vector, requantizes to int8 and emits two packed words
module ofmap_requant
  import requant_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_valid,
  input  logic signed [ACC_W-1:0]        i_psum [LANES],
  output logic                           i_ready,
  input  logic        [4:0]              cfg_shift,
  input  logic                           cfg_relu,
  output logic                           o_valid,
  input  logic                           o_ready,
  output logic        [PACK*OUT_W-1:0]   o_data,
  output logic                           o_last,
  output logic                           o_overflow
);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] psum_q [LANES];
  logic signed [ACC_W-1:0] psum_d [LANES];
  logic [4:0]              shift_q, shift_d;
  logic                    relu_q, relu_d;
  logic [PACK*OUT_W-1:0]   data_q, data_d;
  logic                    overflow_q, overflow_d;

  logic signed [ACC_W-1:0] lane_in  [PACK];
  logic signed [OUT_W-1:0] lane_out [PACK];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        psum_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      relu_q     <= relu_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      for (int k = 0; k < LANES; k++) begin
        psum_q[k] <= psum_d[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_valid) state_d = Q0;
      Q0:      state_d = S0;
      S0:      if (o_ready) state_d = Q1;
      Q1:      state_d = S1;
      S1:      if (o_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_ready    = (state_q == IDLE);
    o_valid    = (state_q == S0) || (state_q == S1);
    o_last     = (state_q == S1);
    o_data     = data_q;
    o_overflow = overflow_q;
  end

  // Q1 is the only state that consumes the upper lane group.
  always_comb begin
    for (int k = 0; k < PACK; k++) begin
      lane_in[k] = (state_q == Q1) ? psum_q[PACK + k] : psum_q[k];
    end
  end

  for (genvar g = 0; g < PACK; g++) begin : g_lane
    requant_lane u_lane (
      .psum  (lane_in[g]),
      .shift (shift_q),
      .relu  (relu_q),
      .q     (lane_out[g])
    );
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      psum_d[k] = psum_q[k];
    end
    shift_d    = shift_q;
    relu_d     = relu_q;
    data_d     = data_q;
    overflow_d = overflow_q | (i_valid && (state_q != IDLE));
    if ((state_q == IDLE) && i_valid) begin
      for (int k = 0; k < LANES; k++) begin
        psum_d[k] = i_psum[k];
      end
      shift_d = cfg_shift;
      relu_d  = cfg_relu;
    end
    if ((state_q == Q0) || (state_q == Q1)) begin
      for (int k = 0; k < PACK; k++) begin
        data_d[k*OUT_W +: OUT_W] = lane_out[k];
      end
    end
  end

endmodule
